// File: rtl/exp_mu_generator.sv
// exp_mu_generator: streams S0*exp(k*mu) for k = 0..2^logT-1 as addressed Q3.15 words.
// Pipeline: capture, t*mu (3), LUT*poly exp (6), S0*exp (3), alignment (3).
module exp_mu_generator #(
    parameter int logT = 9
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [17:0]     iMu,
    input  logic [17:0]     iS,
    input  logic            iStart,
    output logic [17:0]     oData,
    output logic [logT-1:0] oAddr,
    output logic            oValid,
    output logic            oDone
);
    // exp(h/64) in Q2.16, built from an integer Taylor series at elaboration
    function automatic logic [63:0][17:0] gen_lut();
        logic [63:0][17:0] l;
        logic [63:0] x, t, s;
        for (int h = 0; h < 64; h++) begin
            x = 64'(h) << 24;
            t = 64'd1 << 30;
            s = t;
            for (int n = 1; n < 12; n++) begin
                t = ((t * x) >> 30) / 64'(n);
                s = s + t;
            end
            l[h] = 18'((s + 64'd8192) >> 14);
        end
        return l;
    endfunction

    localparam logic [63:0][17:0] exp_lut = gen_lut();

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [17:0]     mu_r, s_r;
    logic [logT:0]   nxt;
    logic [logT-1:0] cnt;
    logic            iss_v;
    logic [logT+17:0] p1_a, p1_b;
    logic [17:0]     x_q;
    logic [5:0]      h_q;
    logic [11:0]     r_q, r2_q;
    logic [23:0]     rr_q;
    logic [17:0]     lut_q, lut2_q;
    logic [18:0]     poly_q;
    logic [36:0]     prod_q, rnd_q;
    logic [17:0]     ex_q;
    logic [35:0]     mp_a, mp_b;
    logic [17:0]     y_q, al_a, al_b;
    logic [logT:0]   dly [14];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            mu_r  <= '0;
            s_r   <= '0;
            nxt   <= '0;
            cnt   <= '0;
            iss_v <= 1'b0;
            oDone <= 1'b0;
        end else begin
            if (state == IDLE) begin
                iss_v <= 1'b0;
                if (iStart) begin
                    state <= RUN;
                    mu_r  <= iMu;
                    s_r   <= iS;
                    nxt   <= '0;
                end
            end else begin
                iss_v <= !nxt[logT];
                if (!nxt[logT]) begin
                    cnt <= nxt[logT-1:0];
                    nxt <= nxt + {{logT{1'b0}}, 1'b1};
                end
                if (oValid && &oAddr)
                    state <= IDLE;
            end
            oDone <= state == RUN && oValid && &oAddr;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p1_a   <= '0;
            p1_b   <= '0;
            x_q    <= '0;
            h_q    <= '0;
            r_q    <= '0;
            r2_q   <= '0;
            rr_q   <= '0;
            lut_q  <= '0;
            lut2_q <= '0;
            poly_q <= '0;
            prod_q <= '0;
            rnd_q  <= '0;
            ex_q   <= '0;
            mp_a   <= '0;
            mp_b   <= '0;
            y_q    <= '0;
            al_a   <= '0;
            al_b   <= '0;
            oData  <= '0;
            oAddr  <= '0;
            oValid <= 1'b0;
            for (int n = 0; n < 14; n++)
                dly[n] <= '0;
        end else begin
            p1_a   <= cnt * mu_r;
            p1_b   <= p1_a;
            x_q    <= |p1_b[logT+17:18] ? 18'h3FFFF : p1_b[17:0];
            h_q    <= x_q[17:12];
            r_q    <= x_q[11:0];
            lut_q  <= exp_lut[h_q];
            rr_q   <= r_q * r_q;
            r2_q   <= r_q;
            lut2_q <= lut_q;
            poly_q <= {1'b1, 18'd0} + {7'd0, r2_q} + 19'(rr_q >> 19);
            prod_q <= lut2_q * poly_q;
            rnd_q  <= prod_q + 37'd524288;
            ex_q   <= 18'(rnd_q >> 20);
            mp_a   <= ex_q * s_r;
            mp_b   <= mp_a;
            y_q    <= |mp_b[35:31] ? 18'h3FFFF : 18'(mp_b >> 13);
            al_a   <= y_q;
            al_b   <= al_a;
            dly[0] <= {iss_v, cnt};
            for (int n = 1; n < 14; n++)
                dly[n] <= dly[n-1];
            oValid <= dly[13][logT];
            oAddr  <= dly[13][logT] ? dly[13][logT-1:0] : '0;
            oData  <= dly[13][logT] ? al_b : '0;
        end
    end
endmodule

// File: tb/tb_exp_mu_generator.sv
// tb_exp_mu_generator: directed runs with hand-computed Q3.15 expectations and timing checks.
module tb_exp_mu_generator;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iStart = 1'b0;
    logic [17:0] iMu = '0;
    logic [17:0] iS = '0;
    logic [17:0] oData;
    logic [8:0]  oAddr;
    logic        oValid, oDone;

    int n_chk = 0;
    int n_err = 0;
    int dq [512];
    int first_v, second_v, n_v, n_done, done_c, ord_err, zero_err;

    exp_mu_generator #(.logT(9)) dut (
        .CLK(CLK), .RST(RST), .iMu(iMu), .iS(iS), .iStart(iStart),
        .oData(oData), .oAddr(oAddr), .oValid(oValid), .oDone(oDone)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int want);
        n_chk++;
        if (obs != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int near(input int obs, input int want);
        return (obs >= want - 4 && obs <= want + 4) ? want : obs;
    endfunction

    // c counts edges after E0; samples are taken on the falling edge that follows edge E0+c
    task automatic run(input logic [17:0] mu, input logic [17:0] s, input bit hold,
                       input int rst_at, input int ncyc);
        int want_addr;
        for (int k = 0; k < 512; k++) dq[k] = -1;
        @(negedge CLK);
        iMu = mu;
        iS = s;
        iStart = 1'b1;
        @(posedge CLK);
        first_v = -1; second_v = -1; n_v = 0; n_done = 0; done_c = -1;
        ord_err = 0; zero_err = 0; want_addr = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            if (!hold) iStart = 1'b0;
            if (c == 10) begin
                iMu = ~mu;
                iS = ~s;
            end
            RST = (c == rst_at - 1);
            if (oValid) begin
                if (c < 540) begin
                    if (first_v < 0) first_v = c;
                    n_v++;
                    if (int'(oAddr) != want_addr) ord_err++;
                    dq[oAddr] = int'(oData);
                    want_addr++;
                end else if (second_v < 0) second_v = c;
            end else if (oData != 0 || oAddr != 0) zero_err++;
            if (oDone) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
        end
        iStart = 1'b0;
        RST = 1'b0;
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_first_valid"}, first_v, 16);
        check({tag, "_valids"}, n_v, 512);
        check({tag, "_done_cycle"}, done_c, 528);
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_order"}, ord_err, 0);
        check({tag, "_idle_zero"}, zero_err, 0);
    endtask

    task automatic check_growth(input string tag);
        int mono;
        mono = 0;
        for (int k = 1; k < 512; k++) if (dq[k] < dq[k-1]) mono++;
        check({tag, "_k0"}, dq[0], 32768);
        check({tag, "_k1"}, near(dq[1], 32784), 32784);
        check({tag, "_k128"}, near(dq[128], 34881), 34881);
        check({tag, "_k256"}, near(dq[256], 37131), 37131);
        check({tag, "_k384"}, near(dq[384], 39526), 39526);
        check({tag, "_k511"}, near(dq[511], 42054), 42054);
        check({tag, "_monotonic"}, mono, 0);
    endtask

    initial begin
        int bad, w, seen;
        repeat (3) @(negedge CLK);
        check("reset_valid", oValid, 0);
        check("reset_done", oDone, 0);
        check("reset_data", oData, 0);
        check("reset_addr", oAddr, 0);

        iStart = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        iStart = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (oValid || oDone) seen++;
        end
        check("reset_priority", seen, 0);

        run(18'h00000, 18'h04000, 1'b0, -1, 540);
        check_timing("unity");
        bad = 0;
        for (int k = 0; k < 512; k++) if (dq[k] != 32768) bad++;
        check("unity_data", bad, 0);

        run(18'h00080, 18'h04000, 1'b0, -1, 540);
        check_timing("growth");
        check_growth("growth");

        run(18'h3FFFF, 18'h3FFFF, 1'b0, -1, 540);
        check_timing("sat");
        bad = 0;
        for (int k = 0; k < 512; k++) if (dq[k] != 18'h3FFFF) bad++;
        check("sat_data", bad, 0);

        run(18'h01000, 18'h08000, 1'b0, -1, 540);
        check("musat_k0", dq[0], 65536);
        check("musat_k32", near(dq[32], 108051), 108051);
        check("musat_k64", near(dq[64], 178145), 178145);
        check("musat_k511", near(dq[511], 178145), 178145);

        run(18'h00080, 18'h04000, 1'b0, 100, 200);
        check("abort_valids", n_v, 84);
        check("abort_done", n_done, 0);
        check("abort_zero", zero_err, 0);

        run(18'h00080, 18'h04000, 1'b0, -1, 540);
        check_timing("fresh");
        check_growth("fresh");

        run(18'h00080, 18'h04000, 1'b1, -1, 560);
        check_timing("hold");
        check("hold_restart", second_v, 545);
        check("hold_k511", near(dq[511], 42054), 42054);
        for (w = 0; w < 700 && !oDone; w++) @(negedge CLK);
        check("hold_run2_done", oDone, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
